// File: rtl/rgb_pwm_driver_pkg.sv
// rgb_pkg -- shared types and defaults for the RGB PWM LED driver.
//
// Contents:
//   RGB_W         default duty/phase width (8 bits)
//   PRESCALE_DEF  default prescaler terminal count: 12 MHz / 47 / 256 ~= 997 Hz frame
//   rgb_t         packed {r,g,b} colour word, RGB_W bits per channel
package rgb_pkg;

  localparam int RGB_W        = 8;
  localparam int PRESCALE_DEF = 46;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if -- valid/ready colour-word channel into the PWM driver.
//
// Signals:
//   in_valid  producer -> driver  colour word valid
//   in_ready  driver -> producer  driver can accept a colour word
//   in_color  producer -> driver  packed {R,G,B} duty values, PWM_BITS each
// Modports: master (producer side), slave (driver side).
interface rgb_pwm_driver_if #(
  parameter int PWM_BITS = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [3*PWM_BITS-1:0]   in_color;

  modport master (output in_valid, output in_color, input in_ready);
  modport slave  (input in_valid, input in_color, output in_ready);

endinterface

// File: rtl/rgb_pwm_driver_channel.sv
// pwm_channel -- one PWM compare stage with a registered active-low output.
//
// Ports:
//   clk, rst  system clock, synchronous active-high reset (output forced to 1 = off)
//   phase_i   current frame phase
//   duty_i    active duty for this channel
//   pwm_o     active-low LED drive, registered one cycle after phase_i
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] phase_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  logic pwm_q;

  // Lit (0) while phase < duty, so duty 0 never lights and the last phase
  // of a frame is always dark.
  always_ff @(posedge clk) begin
    if (rst) pwm_q <= 1'b1;
    else     pwm_q <= ~(phase_i < duty_i);
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver -- three-channel active-low PWM driver for an RGB LED.
//
// Ports:
//   clk          system clock (12 MHz)
//   rst          synchronous active-high reset
//   in_if        rgb_pwm_driver_if.slave: in_valid / in_ready / in_color {R,G,B}
//   frame_start  one-cycle pulse in the cycle the phase counter returns to 0
//   RGB_R/G/B    active-low LED drives (0 = lit)
//
// A colour word is held in a one-entry pending buffer and only moved into the
// active duties at a frame boundary, so a frame never mixes two colours.
//
// Build option: define RGB_PWM_GAMMA_EN to square each duty ((d*d) >> PWM_BITS)
// as it is transferred into the active set; timing is identical either way.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb_pwm_driver_if.slave       in_if,
  output logic                  frame_start,
  output logic                  RGB_R,
  output logic                  RGB_G,
  output logic                  RGB_B
);

  localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  typedef struct packed {
    logic [PWM_BITS-1:0] r;
    logic [PWM_BITS-1:0] g;
    logic [PWM_BITS-1:0] b;
  } duty_t;

  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] d);
`ifdef RGB_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return d;
`endif
  endfunction

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] phase_q, phase_d;
  duty_t               act_q, act_d;
  duty_t               pend_q;
  logic                pend_vld_q, pend_vld_d;
  logic                fs_q;
  logic                tick, boundary, accept;

  assign in_if.in_ready = !pend_vld_q && !rst;

  always_comb begin
    tick       = (presc_q == PS_W'(PRESCALE));
    boundary   = tick && (phase_q == '1);
    accept     = in_if.in_valid && in_if.in_ready;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    phase_d    = tick ? phase_q + 1'b1 : phase_q;
    act_d      = act_q;
    pend_vld_d = pend_vld_q;
    if (boundary && pend_vld_q) begin
      act_d.r    = gamma(pend_q.r);
      act_d.g    = gamma(pend_q.g);
      act_d.b    = gamma(pend_q.b);
      pend_vld_d = 1'b0;
    end
    // Accept only happens with the buffer empty, so it never races the
    // transfer above; a word accepted on a boundary waits a full frame.
    if (accept) pend_vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      phase_q    <= '0;
      act_q      <= '0;
      pend_vld_q <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      act_q      <= act_d;
      pend_vld_q <= pend_vld_d;
      fs_q       <= boundary;
    end
  end

  // Pending data is qualified by pend_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) pend_q <= duty_t'(in_if.in_color);
  end

  assign frame_start = fs_q;

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk(clk), .rst(rst), .phase_i(phase_q), .duty_i(act_q.r), .pwm_o(RGB_R)
  );
  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk(clk), .rst(rst), .phase_i(phase_q), .duty_i(act_q.g), .pwm_o(RGB_G)
  );
  pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk(clk), .rst(rst), .phase_i(phase_q), .duty_i(act_q.b), .pwm_o(RGB_B)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
module tb_rgb_pwm_driver;
  import rgb_pkg::*;

  localparam int PW    = 8;
  localparam int FRAME = 1 << PW;
  localparam int BOUND = 3 * FRAME;

  logic clk = 1'b0;
  logic rst;
  logic frame_start, RGB_R, RGB_G, RGB_B;

  rgb_pwm_driver_if #(.PWM_BITS(PW)) bus ();

  rgb_pwm_driver #(.PWM_BITS(PW), .PRESCALE(0)) dut (
    .clk(clk), .rst(rst), .in_if(bus), .frame_start(frame_start),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  rgb_t exp_q[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_chan(input logic [7:0] d);
`ifdef RGB_PWM_GAMMA_EN
    return 8'((int'(d) * int'(d)) >> PW);
`else
    return d;
`endif
  endfunction

  function automatic rgb_t exp_duty(input rgb_t c);
    rgb_t e;
    e.r = exp_chan(c.r);
    e.g = exp_chan(c.g);
    e.b = exp_chan(c.b);
    return e;
  endfunction

  task automatic chk_rgb(input string tag, input rgb_t got, input rgb_t exp);
    chk({tag, "_r"}, int'(got.r), int'(exp.r));
    chk({tag, "_g"}, int'(got.g), int'(exp.g));
    chk({tag, "_b"}, int'(got.b), int'(exp.b));
  endtask

  // Advance negedge by negedge until frame_start is seen (bounded).
  task automatic wait_fs(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < BOUND);
    chk(tag, int'(frame_start), 1);
  endtask

  // Called on a negedge where frame_start is high. Counts lit cycles over
  // the following frame (outputs lag phase by one cycle) and ends on the
  // next frame_start negedge. in_valid is released after the first edge.
  task automatic measure(input string tag, output rgb_t got);
    int lr = 0, lg = 0, lb = 0, nfs = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) bus.in_valid = 1'b0;
      lr += int'(!RGB_R);
      lg += int'(!RGB_G);
      lb += int'(!RGB_B);
      nfs += int'(frame_start);
    end
    chk({tag, "_fs_end"}, int'(frame_start), 1);
    chk({tag, "_fs_cnt"}, nfs, 1);
    got.r = 8'(lr);
    got.g = 8'(lg);
    got.b = 8'(lb);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input string tag, input rgb_t c);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_color = c;
    while (!bus.in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rgb_t w, got, prev;
    int   n;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_color = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_rgb", int'({RGB_R, RGB_G, RGB_B}), 7);
      chk("rst_ready", int'(bus.in_ready), 0);
      chk("rst_fs", int'(frame_start), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", int'(bus.in_ready), 1);

    // Basic duty: R=64, G=0, B=255
    w = '{r: 8'd64, g: 8'd0, b: 8'd255};
    send("w1", w);
    exp_q.push_back(exp_duty(w));
    chk("w1_full", int'(bus.in_ready), 0);
    wait_fs("w1_act");
    measure("w1_f1", got);
    prev = exp_q.pop_front();
    chk_rgb("w1_f1", got, prev);
    measure("w1_f2", got);
    chk_rgb("w1_f2", got, prev);

    // Back-to-back words: second waits for the boundary that activates the first
    w = '{r: 8'd200, g: 8'd1, b: 8'd17};
    send("wa", w);
    exp_q.push_back(exp_duty(w));
    chk("wa_full", int'(bus.in_ready), 0);
    w = '{r: 8'd5, g: 8'd128, b: 8'd254};
    bus.in_valid = 1'b1;
    bus.in_color = w;
    n = 0;
    while (!bus.in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("wb_ready_at_fs", int'(frame_start), 1);
    exp_q.push_back(exp_duty(w));
    measure("wa_frame", got);
    chk_rgb("wa_frame", got, exp_q.pop_front());
    measure("wb_frame", got);
    prev = exp_q.pop_front();
    chk_rgb("wb_frame", got, prev);

    // Accept in the boundary cycle: word only applies a frame later
    repeat (FRAME - 1) @(negedge clk);
    w = '{r: 8'd33, g: 8'd99, b: 8'd3};
    bus.in_valid = 1'b1;
    bus.in_color = w;
    chk("wc_ready", int'(bus.in_ready), 1);
    exp_q.push_back(exp_duty(w));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("wc_fs", int'(frame_start), 1);
    chk("wc_pending", int'(bus.in_ready), 0);
    measure("wc_old", got);
    chk_rgb("wc_old", got, prev);
    measure("wc_new", got);
    chk_rgb("wc_new", got, exp_q.pop_front());

    // Mid-frame reset at phase 100 with a word pending
    w = '{r: 8'd77, g: 8'd77, b: 8'd77};
    send("wd", w);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rgb", int'({RGB_R, RGB_G, RGB_B}), 7);
    chk("mrst_fs", int'(frame_start), 0);
    chk("mrst_ready", int'(bus.in_ready), 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("mrst_drop", int'(bus.in_ready), 1);
    end while (!frame_start && n < BOUND);
    chk("mrst_fs_delay", n, FRAME);
    measure("mrst_frame", got);
    chk_rgb("mrst_frame", got, '{r: 8'd0, g: 8'd0, b: 8'd0});

    // Gamma-sensitive word
    w = '{r: 8'd128, g: 8'd16, b: 8'd255};
    send("wg", w);
    exp_q.push_back(exp_duty(w));
    wait_fs("wg_act");
    measure("wg_frame", got);
    chk_rgb("wg_frame", got, exp_q.pop_front());
    chk("q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
